// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch FSM encoding and PC constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JR > J/JAL > taken branch > sequential, all 32-bit modulo.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_eq_i,
  input  logic        branch_ne_i,
  input  logic        zero_i,
  input  logic        jump_i,
  input  logic        jal_i,
  input  logic        jr_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] address_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        branch_taken_o
);

  logic [31:0] branch_off;
  logic [31:0] jump_target;
  logic [31:0] jr_target;

  always_comb begin
    pc_plus4_o     = pc_i + PC_STEP;
    branch_taken_o = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
    branch_off     = {{14{imm_i[15]}}, imm_i, 2'b00};
    jump_target    = {pc_plus4_o[31:28], address_i, 2'b00};
    // JR targets are forced word aligned rather than trapping on misalignment
    jr_target      = rs_data_i & ~32'h0000_0003;

    if (jr_i)                next_pc_o = jr_target;
    else if (jump_i | jal_i) next_pc_o = jump_target;
    else if (branch_taken_o) next_pc_o = pc_plus4_o + branch_off;
    else                     next_pc_o = pc_plus4_o;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS PC register and fetch FSM: imem req/ack on one side, valid/accept to decode on the other.
// Build option FETCH_TIMEOUT_EN adds a REQ watchdog that parks the unit in a sticky ERROR state.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        instr_accept_i,
  input  logic        branch_eq_i,
  input  logic        branch_ne_i,
  input  logic        zero_i,
  input  logic [15:0] imm_i,
  input  logic        jump_i,
  input  logic        jal_i,
  input  logic        jr_i,
  input  logic [25:0] address_i,
  input  logic [31:0] rs_data_i,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        link_we_o,
  output logic [31:0] link_o,
  output logic        fetch_error_o
);

  // states: IDLE one-cycle gap after reset | REQ fetching | HOLD instr presented | ERROR fetch timed out

  if (RESET_PC[1:0] != 2'b00 || FETCH_TIMEOUT == 0) begin : g_param_check
    $error("pc_fetch_unit: RESET_PC must be word aligned and FETCH_TIMEOUT nonzero");
  end

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         req_q;
  logic         link_we_q;
  logic [31:0]  link_q;
  logic         branch_taken_unused;

  next_pc_calc u_next_pc (
    .pc_i           (pc_q),
    .branch_eq_i    (branch_eq_i),
    .branch_ne_i    (branch_ne_i),
    .zero_i         (zero_i),
    .jump_i         (jump_i),
    .jal_i          (jal_i),
    .jr_i           (jr_i),
    .imm_i          (imm_i),
    .address_i      (address_i),
    .rs_data_i      (rs_data_i),
    .next_pc_o      (pc_d),
    .pc_plus4_o     (pc_plus4_o),
    .branch_taken_o (branch_taken_unused)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(FETCH_TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q;
  logic            err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      link_we_q <= 1'b0;
      link_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      link_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_HOLD;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= '0;
          end else if (tmo_q == TmoW'(FETCH_TIMEOUT - 1)) begin
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_ERROR;
          end else begin
            tmo_q   <= tmo_q + 1'b1;
`endif
          end
        end
        ST_HOLD: begin
          if (instr_accept_i && !stall_i) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
            if (jal_i) begin
              link_q    <= pc_plus4_o;
              link_we_q <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign link_we_o     = link_we_q;
  assign link_o        = link_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_error_o = err_q;
`else
  assign fetch_error_o = 1'b0;
`endif

endmodule
